// File: rtl/rmw_long_latency_pkg.sv
// rtl/rmw_long_latency_pkg.sv - shared types and widths for the RMW engine table interface
//
// Purpose: common id/word/tag types, the table read request record and the
// latency bound used by the long-latency table responder.

package rmw_long_latency_pkg;

  localparam int ID_W            = 4;
  localparam int WORD_W          = 8;
  localparam int TAG_W           = 4;
  localparam int TBL_LATENCY_MAX = 16;
  localparam int INFLIGHT_W      = 5;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef struct packed {
    logic vld;
    id_t  id;
    tag_t tag;
  } tbl_rd_req_t;

endpackage

// File: rtl/rmw_long_latency_tbl_dly.sv
// rtl/rmw_long_latency_tbl_dly.sv - LATENCY-1 stage delay line for table read requests
//
// Purpose: carries accepted read requests from the sampling edge to the edge
// that loads the response register.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset (clears valid bits only)
//   req_in   in   request sampled this cycle
//   req_out  out  request that reaches the response-load edge

module rmw_long_latency_tbl_dly
  import rmw_long_latency_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  tbl_rd_req_t req_in,
  output tbl_rd_req_t req_out
);

  if (LATENCY <= 1) begin : g_pass
    // Response register itself provides the single cycle of latency.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign req_out        = req_in;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;

    logic [STAGES-1:0] vld_q;
    id_t               id_q  [STAGES];
    tag_t              tag_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= req_in.vld;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Payload needs no reset: it is only consumed alongside a set valid bit.
    always_ff @(posedge clk) begin
      id_q[0]  <= req_in.id;
      tag_q[0] <= req_in.tag;
      for (int i = 1; i < STAGES; i++) begin
        id_q[i]  <= id_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end

    assign req_out = {vld_q[STAGES-1], id_q[STAGES-1], tag_q[STAGES-1]};
  end

endmodule

// File: rtl/rmw_long_latency_tbl.sv
// rtl/rmw_long_latency_tbl.sv - long-latency word table responder for the RMW engine
//
// Purpose: word table indexed by id; one write and one read per cycle, reads
// answered in order exactly LATENCY cycles after sampling.
// Ports:
//   clk                in   clock
//   rst                in   asynchronous active-low reset
//   tbl_wr_r           in   write strobe
//   tbl_wr_id_r        in   write index
//   tbl_wr_word_r      in   write data
//   tbl_rd_r           in   read strobe (no backpressure)
//   tbl_rd_id_r        in   read index
//   tbl_rd_itag_r      in   requester tag
//   tbl_rd_word_vld_r  out  response valid pulse
//   tbl_rd_word_r      out  response data (holds while not valid)
//   tbl_rd_ctag_r      out  completion tag (holds while not valid)
//   tbl_rd_inflight_r  out  reads accepted but not yet responded

module rmw_long_latency_tbl
  import rmw_long_latency_pkg::*;
#(
  parameter int                LATENCY = 4,
  parameter logic [WORD_W-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_wr_r,
  input  logic [ID_W-1:0]       tbl_wr_id_r,
  input  logic [WORD_W-1:0]     tbl_wr_word_r,
  input  logic                  tbl_rd_r,
  input  logic [ID_W-1:0]       tbl_rd_id_r,
  input  logic [TAG_W-1:0]      tbl_rd_itag_r,
  output logic                  tbl_rd_word_vld_r,
  output logic [WORD_W-1:0]     tbl_rd_word_r,
  output logic [TAG_W-1:0]      tbl_rd_ctag_r,
  output logic [INFLIGHT_W-1:0] tbl_rd_inflight_r
);

  localparam int DEPTH = 2 ** ID_W;

  word_t       tbl_q [DEPTH];
  tbl_rd_req_t req_in;
  tbl_rd_req_t head;
  word_t       head_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= RST_VAL;
      end
    end else if (tbl_wr_r) begin
      tbl_q[tbl_wr_id_r] <= tbl_wr_word_r;
    end
  end

  assign req_in = {tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r};

  rmw_long_latency_tbl_dly #(
    .LATENCY (LATENCY)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .req_out (head)
  );

  // Data is taken on the response-load edge; a write landing on that same
  // edge is forwarded so the response carries the new word.
  always_comb begin
    head_word = tbl_q[head.id];
    if (tbl_wr_r && (tbl_wr_id_r == head.id)) begin
      head_word = tbl_wr_word_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_rd_word_vld_r <= 1'b0;
      tbl_rd_word_r     <= '0;
      tbl_rd_ctag_r     <= '0;
      tbl_rd_inflight_r <= '0;
    end else begin
      tbl_rd_word_vld_r <= head.vld;
      if (head.vld) begin
        tbl_rd_word_r <= head_word;
        tbl_rd_ctag_r <= head.tag;
      end
      // A read stops counting once its valid cycle has been presented.
      tbl_rd_inflight_r <= tbl_rd_inflight_r
                         + INFLIGHT_W'(tbl_rd_r)
                         - INFLIGHT_W'(tbl_rd_word_vld_r);
    end
  end

endmodule
